// File: rtl/mult_share_sched_if.sv
// Handshake bundle between the issuing lanes, the scheduler and the shared
// combinational multiplier unit.
//   req_valid/req_ready : per-requester operand handshake (ready is one-hot)
//   req_a/req_b         : operands, requester i in element [i]
//   mul_a/mul_b/mul_y   : operands to / product from the multiplier unit
//   rsp_*               : single response channel (product + owner ID)
// master = lanes + multiplier unit + response consumer, slave = scheduler.
interface mult_share_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][W-1:0]  req_a;
    logic [NREQ-1:0][W-1:0]  req_b;
    logic [W-1:0]            mul_a;
    logic [W-1:0]            mul_b;
    logic [2*W-1:0]          mul_y;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [2*W-1:0]          rsp_y;

    modport master (
        output req_valid, req_a, req_b, mul_y, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_y, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_y
    );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one combinational multiplier among NREQ
// requesters. One operation in flight at a time: IDLE accepts, ISSUE drives
// the unit for one cycle and captures its product, RESP holds the response
// until the consumer takes it. Zero operands skip ISSUE.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   bus        : request / multiplier / response bundle (slave side)
//   busy_o     : high whenever not IDLE
//   op_count_o : completed responses, saturating
module mult_share_sched #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    mult_share_sched_if.slave bus,
    output logic             busy_o,
    output logic [CNTW-1:0]  op_count_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic           vld_q, vld_d;
    logic [IDW-1:0] id_q, id_d;
    logic [2*W-1:0] y_q, y_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;

    // First valid requester at or after rr_q, wrapping modulo NREQ.
    always_comb begin : arbiter
        int             j;
        logic [IDW-1:0] jj;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        jj        = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IDW'(j);
            if (!gnt_found && bus.req_valid[jj]) begin
                gnt_found = 1'b1;
                gnt_idx   = jj;
            end
        end
    end

    // Ready is masked during reset so a request seen then is never treated
    // as accepted by the lane.
    assign bus.req_ready = (rst_ni && state_q == S_IDLE && gnt_found)
                         ? (NREQ'(1) << gnt_idx) : '0;

    // The unit only sees operands during ISSUE; a zero bypass never drives it.
    assign bus.mul_a     = (state_q == S_ISSUE) ? opa_q : '0;
    assign bus.mul_b     = (state_q == S_ISSUE) ? opb_q : '0;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_y     = y_q;
    assign busy_o        = (state_q != S_IDLE);
    assign op_count_o    = cnt_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        vld_d   = vld_q;
        id_d    = id_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    opa_d = bus.req_a[gnt_idx];
                    opb_d = bus.req_b[gnt_idx];
                    id_d  = gnt_idx;
                    if (bus.req_a[gnt_idx] == '0 || bus.req_b[gnt_idx] == '0) begin
                        y_d     = '0;
                        vld_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                y_d     = bus.mul_y;
                vld_d   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (vld_q && bus.rsp_ready) begin
                    vld_d   = 1'b0;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    // Next search starts just past the requester we served.
                    rr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: main instance (CNTW=16) with a scoreboard on
// grants/responses plus directed checks, and a CNTW=2 instance for saturation.
module tb_mult_share_sched;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_share_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) m ();
    mult_share_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) s ();

    logic        busy, busy_s;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;

    mult_share_sched #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(m.slave), .busy_o(busy), .op_count_o(cnt));
    mult_share_sched #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .bus(s.slave), .busy_o(busy_s), .op_count_o(cnt_s));

    // Approximate multiplier unit model.
    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 0 || b == 0) return 64'd0;
        if (b == 1) return {32'd0, a};
        return {31'd0, a, 1'b0};
    endfunction

    assign m.mul_y = mul_model(m.mul_a, m.mul_b);
    assign s.mul_y = mul_model(s.mul_a, s.mul_b);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    y;
    } exp_t;

    exp_t sbq[$];
    int   rr_m = 0;

    // Scoreboard: push on accept, pop on response handshake.
    always @(negedge clk) begin
        int   g;
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            rr_m = 0;
        end else begin
            if (m.req_ready != 0) begin
                g = pick(m.req_valid, rr_m);
                if (g < 0) chk("grant_spurious", 64'(m.req_ready), 64'd0);
                else begin
                    chk("sb_grant", 64'(m.req_ready), 64'(1 << g));
                    e.id = IDW'(g);
                    e.y  = mul_model(m.req_a[g], m.req_b[g]);
                    sbq.push_back(e);
                end
            end
            if (m.rsp_valid && m.rsp_ready) begin
                if (sbq.size() == 0) chk("sb_empty", 64'd0, 64'd1);
                else begin
                    e = sbq.pop_front();
                    chk("sb_id", 64'(m.rsp_id), 64'(e.id));
                    chk("sb_y", m.rsp_y, e.y);
                    rr_m = (int'(e.id) + 1) % NREQ;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          nrsp, last, c, w;
        logic [63:0] ey;

        rst_n       = 1'b0;
        m.req_valid = '1;
        m.req_a     = '0;
        m.req_b     = '0;
        m.rsp_ready = 1'b0;
        s.req_valid = '0;
        s.req_a     = '0;
        s.req_b     = '0;
        s.rsp_ready = 1'b0;
        repeat (2) tick();

        // Reset state; req_valid held high during reset must be ignored.
        chk("rst_ready", 64'(m.req_ready), 64'd0);
        chk("rst_valid", 64'(m.rsp_valid), 64'd0);
        chk("rst_id",    64'(m.rsp_id),    64'd0);
        chk("rst_y",     m.rsp_y,          64'd0);
        chk("rst_busy",  64'(busy),        64'd0);
        chk("rst_cnt",   64'(cnt),         64'd0);
        chk("rst_mula",  64'(m.mul_a),     64'd0);

        // Single request.
        rst_n       = 1'b1;
        m.req_a[0]  = 32'd5;
        m.req_b[0]  = 32'd3;
        m.req_valid = 4'b0001;
        m.rsp_ready = 1'b1;
        #1;
        chk("t1_ready", 64'(m.req_ready), 64'd1);
        tick();
        m.req_valid = '0;
        chk("t1_c1_valid", 64'(m.rsp_valid), 64'd0);
        chk("t1_mula", 64'(m.mul_a), 64'd5);
        chk("t1_mulb", 64'(m.mul_b), 64'd3);
        tick();
        chk("t1_c2_valid", 64'(m.rsp_valid), 64'd1);
        chk("t1_y",  m.rsp_y, 64'd10);
        chk("t1_id", 64'(m.rsp_id), 64'd0);
        tick();
        chk("t1_cnt",  64'(cnt), 64'd1);
        chk("t1_drop", 64'(m.rsp_valid), 64'd0);

        // Zero bypass on requester 2.
        m.req_a[2]  = 32'h1234;
        m.req_b[2]  = 32'd0;
        m.req_valid = 4'b0100;
        #1;
        chk("t2_ready", 64'(m.req_ready), 64'h4);
        chk("t2_mula0", 64'(m.mul_a), 64'd0);
        tick();
        m.req_valid = '0;
        chk("t2_valid", 64'(m.rsp_valid), 64'd1);
        chk("t2_y",  m.rsp_y, 64'd0);
        chk("t2_id", 64'(m.rsp_id), 64'd2);
        chk("t2_mula", 64'(m.mul_a), 64'd0);
        chk("t2_mulb", 64'(m.mul_b), 64'd0);
        tick();
        chk("t2_cnt", 64'(cnt), 64'd2);

        // Round-robin fairness from a fresh pointer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            m.req_a[i] = 32'(100 + 11 * i);
            m.req_b[i] = (i == 1) ? 32'd1 : 32'(i + 2);
        end
        m.req_valid = '1;
        m.rsp_ready = 1'b1;
        nrsp = 0; last = -1; c = 0;
        while (nrsp < 8 && c < 40) begin
            #1;
            if (m.req_ready != 0) begin
                chk("t3_onehot", 64'($countones(m.req_ready)), 64'd1);
                if (last >= 0) chk("t3_gap", 64'(c - last), 64'd3);
                last = c;
            end
            if (m.rsp_valid) begin
                chk("t3_id", 64'(m.rsp_id), 64'(nrsp % NREQ));
                nrsp++;
            end
            if (nrsp == 8) m.req_valid = '0;
            tick();
            c++;
        end
        chk("t3_count", 64'(nrsp), 64'd8);

        // Backpressure in RESP with all others requesting.
        m.req_valid = '1;
        m.rsp_ready = 1'b0;
        #1;
        chk("t4_grant", 64'(m.req_ready), 64'd1);
        ey = mul_model(m.req_a[0], m.req_b[0]);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t4_valid", 64'(m.rsp_valid), 64'd1);
            chk("t4_y",     m.rsp_y, ey);
            chk("t4_id",    64'(m.rsp_id), 64'd0);
            chk("t4_noready", 64'(m.req_ready), 64'd0);
            chk("t4_busy",  64'(busy), 64'd1);
            tick();
        end
        m.rsp_ready = 1'b1;
        tick();
        #1;
        chk("t4_next", 64'(m.req_ready), 64'h2);
        m.req_valid = '0;
        tick();

        // Reset while in ISSUE aborts the operation.
        m.req_a[3]  = 32'd7;
        m.req_b[3]  = 32'd1;
        m.req_valid = 4'b1000;
        #1;
        chk("t5_grant", 64'(m.req_ready), 64'h8);
        tick();
        m.req_valid = '0;
        chk("t5_busy", 64'(busy), 64'd1);
        chk("t5_mula", 64'(m.mul_a), 64'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_valid", 64'(m.rsp_valid), 64'd0);
        chk("t5_cnt",   64'(cnt), 64'd0);
        chk("t5_idle",  64'(busy), 64'd0);
        repeat (4) begin
            tick();
            chk("t5_novalid", 64'(m.rsp_valid), 64'd0);
        end
        m.req_a[0]  = 32'd7;
        m.req_b[0]  = 32'd1;
        m.req_valid = 4'b0001;
        #1;
        chk("t5_regrant", 64'(m.req_ready), 64'd1);
        tick();
        m.req_valid = '0;
        tick();
        chk("t5_y",  m.rsp_y, 64'd7);
        chk("t5_id", 64'(m.rsp_id), 64'd0);
        tick();
        chk("t5_cnt1", 64'(cnt), 64'd1);

        // Saturation on the CNTW=2 instance.
        s.req_a[0]  = 32'd3;
        s.req_b[0]  = 32'd5;
        s.rsp_ready = 1'b1;
        s.req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!s.rsp_valid && w < 10) begin
                tick();
                w++;
            end
            chk("t6_rsp_seen", 64'(s.rsp_valid), 64'd1);
            chk("t6_y", s.rsp_y, 64'd6);
            tick();
            chk("t6_cnt", 64'(cnt_s), 64'((k + 1 > 3) ? 3 : k + 1));
        end
        s.req_valid = '0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
